instr_fetch: RTL and testbench

- Instruction fetch unit for the single-cycle MIPS core.
- Produces instruction words for the main control decoder and datapath, which consume the opcode field.
- Owns the PC, fetches from instruction memory over a req/ack handshake, and presents each word with a valid/ready handshake.
- On consumption, computes the next PC as sequential, beq target, or j target.

---
 rtl/instr_fetch.sv | 102 ++++++++++
 tb/tb_instr_fetch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches over an imem req/ack handshake and
// hands each word to decode over valid/ready, then steps the PC (sequential, beq, j).
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  output logic        fetch_err,
  output logic [31:0] retired_cnt
);

  localparam logic [31:0] PC0      = RESET_PC & ~32'h3;
  localparam logic [7:0]  TMO_LAST = 8'(ACK_TIMEOUT - 1);

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [7:0]  tcnt;

  // Successor of the consumed instruction; taken only matters for beq.
  function automatic logic [31:0] next_pc_f(input logic [31:0] word,
                                            input logic [31:0] at_pc,
                                            input logic        taken);
    logic        [31:0] p4;
    logic signed [31:0] boff;
    p4   = at_pc + 32'd4;
    boff = {{14{word[15]}}, word[15:0], 2'b00};
    if (word[31:26] == OP_J)
      next_pc_f = {p4[31:28], word[25:0], 2'b00};
    else if (word[31:26] == OP_BEQ && taken)
      next_pc_f = p4 + boff;
    else
      next_pc_f = p4;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= PC0;
      tcnt        <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= PC0;
      instr       <= '0;
      instr_pc    <= PC0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      retired_cnt <= '0;
    end else begin
      case (state)
        S_REQ: begin
          imem_req  <= 1'b1;
          imem_addr <= pc;
          tcnt      <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= S_HOLD;
          end else if (tcnt == TMO_LAST) begin
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            state     <= S_ERR;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            retired_cnt <= retired_cnt + 32'd1;
            pc          <= next_pc_f(instr, instr_pc, branch_taken);
            state       <= S_REQ;
          end
        end
        default: begin
          // Terminal until reset.
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a small memory responder pushes each delivered
// word with its address, and the consume handshake pops and compares it.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        fetch_err;
  logic [31:0] retired_cnt;

  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] exp_ret = 32'h0;

  instr_fetch #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .fetch_err(fetch_err),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] at, input logic [31:0] w,
                                             input logic bt);
    logic        [31:0] seq;
    logic signed [31:0] off;
    seq = at + 32'd4;
    off = $signed(w[15:0]);
    off = off <<< 2;
    if (w[31:26] == 6'd2)
      return {seq[31:28], w[25:0], 2'b00};
    if (w[31:26] == 6'd4 && bt)
      return seq + off;
    return seq;
  endfunction

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_latency", 32'(n), 32'd1);
  endtask

  task automatic fetch_one(input logic [31:0] word, input int ack_dly, input int rdy_dly,
                           input logic bt);
    logic [63:0] e;
    wait_req();
    chk("imem_addr", imem_addr, exp_pc);
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    sb.push_back({exp_pc, word});
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = '0;
    chk("valid_set", 32'(instr_valid), 32'd1);
    chk("req_drop", 32'(imem_req), 32'd0);
    for (int i = 0; i < rdy_dly; i++) begin
      imem_ack = 1'b1;
      imem_rdata = ~word;
      @(negedge clk);
      chk("hold_instr", instr, word);
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_valid", 32'(instr_valid), 32'd1);
    end
    imem_ack = 1'b0;
    imem_rdata = '0;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      e = '0;
    end else begin
      e = sb.pop_front();
      chk("instr", instr, e[31:0]);
      chk("instr_pc", instr_pc, e[63:32]);
    end
    instr_ready = 1'b1;
    branch_taken = bt;
    @(negedge clk);
    instr_ready = 1'b0;
    branch_taken = 1'b0;
    exp_pc = model_next(e[63:32], e[31:0], bt);
    exp_ret = exp_ret + 32'd1;
    chk("retired_cnt", retired_cnt, exp_ret);
    chk("valid_clr", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    int n;
    #3;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_retired", retired_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_req", 32'(imem_req), 32'd0);

    // Sequential fetch, then backpressure with stray acks during HOLD.
    fetch_one(32'h2008_0005, 0, 0, 1'b0);
    fetch_one(32'h0000_0000, 0, 0, 1'b0);
    chk("two_retired", retired_cnt, 32'd2);
    fetch_one(32'h2009_0001, 0, 5, 1'b0);

    // beq at 0x10 taken -> 0x0C, then not taken -> 0x14.
    fetch_one(32'h0000_0000, 0, 0, 1'b0);
    fetch_one(32'h1000_FFFE, 0, 0, 1'b1);
    fetch_one(32'h0000_0000, 0, 0, 1'b0);
    fetch_one(32'h1000_FFFE, 0, 0, 1'b0);

    // Far negative beq wraps the PC high, then j keeps p4[31:28].
    fetch_one(32'h1000_FFC0, 0, 0, 1'b1);
    fetch_one(32'h0800_0100, 0, 0, 1'b0);
    fetch_one(32'h2008_0005, 0, 0, 1'b1);
    fetch_one(32'h0000_0000, 3, 0, 1'b0);

    // Timeout: never ack.
    wait_req();
    chk("tmo_addr", imem_addr, exp_pc);
    n = 0;
    while (!fetch_err && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'd16);
    chk("err_req", 32'(imem_req), 32'd0);
    instr_ready = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (4) @(negedge clk);
    instr_ready = 1'b0;
    imem_ack = 1'b0;
    chk("err_sticky", 32'(fetch_err), 32'd1);
    chk("err_valid", 32'(instr_valid), 32'd0);
    chk("err_req_hold", 32'(imem_req), 32'd0);
    chk("err_retired", retired_cnt, exp_ret);

    // Reset out of ERR, then async reset in the middle of WAIT.
    rst_n = 1'b0;
    #1;
    chk("rst2_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 32'h0;
    exp_ret = 32'h0;
    wait_req();
    chk("rst2_addr", imem_addr, 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_retired", retired_cnt, 32'h0);
    chk("async_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch_one(32'h2008_0005, 0, 0, 1'b0);
    chk("post_rst_retired", retired_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
